// File: rtl/sw_array_ctrl_if.sv
// Host-side bundle of the Smith-Waterman array controller: job request,
// scoring configuration, query/target symbol streams and job status.
interface sw_array_ctrl_if #(
   parameter int VW   = 16,
   parameter int LENW = 16
);
   logic                   start;
   logic [LENW-1:0]        q_len;
   logic [LENW-1:0]        t_len;
   logic signed [VW-1:0]   cfg_match;
   logic signed [VW-1:0]   cfg_mismatch;
   logic signed [VW-1:0]   cfg_minus_alpha;
   logic signed [VW-1:0]   cfg_minus_beta;
   logic                   q_valid;
   logic                   q_ready;
   logic [1:0]             q_data;
   logic                   t_valid;
   logic                   t_ready;
   logic [1:0]             t_data;
   logic                   busy;
   logic                   done;
   logic                   error;
   logic [VW-1:0]          best_score;

   // Controller side
   modport slave (
      input  start, q_len, t_len,
      input  cfg_match, cfg_mismatch, cfg_minus_alpha, cfg_minus_beta,
      input  q_valid, q_data, t_valid, t_data,
      output q_ready, t_ready, busy, done, error, best_score
   );

   // Host side
   modport master (
      output start, q_len, t_len,
      output cfg_match, cfg_mismatch, cfg_minus_alpha, cfg_minus_beta,
      output q_valid, q_data, t_valid, t_data,
      input  q_ready, t_ready, busy, done, error, best_score
   );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencer for the linear Smith-Waterman PE chain: latches a job, shifts
// the query into the chain, streams the target through PE0 under a single
// advance enable, drains the pipeline and tracks the best cell score.
module sw_array_ctrl #(
   parameter int NUM_PE = 64,
   parameter int VW     = 16,
   parameter int LENW   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   sw_array_ctrl_if.slave         host,
   output logic                   pe_s_shift,
   output logic [1:0]             pe_s_data,
   output logic                   pe_en,
   output logic [1:0]             pe_t,
   output logic                   pe_newline,
   output logic [LENW-1:0]        pe_active,
   output logic signed [VW-1:0]   match,
   output logic signed [VW-1:0]   mismatch,
   output logic signed [VW-1:0]   minus_alpha,
   output logic signed [VW-1:0]   minus_beta,
   input  logic [VW-1:0]          score_in
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FINISH} stateT;

   stateT            state;
   logic [LENW-1:0]  qLen;
   logic [LENW-1:0]  tLen;
   logic [LENW-1:0]  cnt;
   logic [LENW-1:0]  cntInc;
   logic             busyR;
   logic             qReadyR;
   logic             tReadyR;
   logic             doneR;
   logic             errorR;
   logic [VW-1:0]    bestR;
   logic             firstBeat;
   logic             enD_p1;
   logic             qBeat;
   logic             tBeat;

   // Lengths must fit the chain and describe a non-empty job; this also
   // guarantees the LENW-bit counters never wrap.
   function automatic logic lenLegal(input logic [LENW-1:0] ql,
                                     input logic [LENW-1:0] tl);
      return (ql != '0) && (ql <= LENW'(NUM_PE)) && (tl != '0);
   endfunction

   assign cntInc = cnt + LENW'(1);
   assign qBeat  = qReadyR & host.q_valid;
   assign tBeat  = tReadyR & host.t_valid;

   // Job sequencing, configuration latching and best-score tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         qLen        <= '0;
         tLen        <= '0;
         cnt         <= '0;
         busyR       <= 1'b0;
         qReadyR     <= 1'b0;
         tReadyR     <= 1'b0;
         doneR       <= 1'b0;
         errorR      <= 1'b0;
         bestR       <= '0;
         firstBeat   <= 1'b0;
         enD_p1      <= 1'b0;
         match       <= '0;
         mismatch    <= '0;
         minus_alpha <= '0;
         minus_beta  <= '0;
      end else begin
         doneR  <= 1'b0;
         // score_in reflects the chain update made while pe_en was high
         enD_p1 <= pe_en;
         if (enD_p1 && (score_in > bestR))
            bestR <= score_in;

         unique case (state)
            IDLE: begin
               // the done cycle itself still counts as finishing the job
               if (host.start && !doneR) begin
                  qLen        <= host.q_len;
                  tLen        <= host.t_len;
                  match       <= host.cfg_match;
                  mismatch    <= host.cfg_mismatch;
                  minus_alpha <= host.cfg_minus_alpha;
                  minus_beta  <= host.cfg_minus_beta;
                  if (!lenLegal(host.q_len, host.t_len)) begin
                     doneR  <= 1'b1;
                     errorR <= 1'b1;
                  end else begin
                     errorR  <= 1'b0;
                     bestR   <= '0;
                     cnt     <= '0;
                     busyR   <= 1'b1;
                     qReadyR <= 1'b1;
                     state   <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (qBeat) begin
                  cnt <= cntInc;
                  if (cntInc == qLen) begin
                     cnt       <= '0;
                     qReadyR   <= 1'b0;
                     tReadyR   <= 1'b1;
                     firstBeat <= 1'b1;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (tBeat) begin
                  firstBeat <= 1'b0;
                  cnt       <= cntInc;
                  if (cntInc == tLen) begin
                     cnt     <= '0;
                     tReadyR <= 1'b0;
                     state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               cnt <= cntInc;
               if (cntInc == qLen) begin
                  cnt   <= '0;
                  state <= FINISH;
               end
            end
            FINISH: begin
               busyR <= 1'b0;
               doneR <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Same-cycle chain controls: query pass-through and advance gating
   always_comb begin
      pe_s_shift = qBeat;
      pe_s_data  = qBeat ? host.q_data : 2'd0;
      pe_en      = tBeat | (state == DRAIN);
      pe_t       = tBeat ? host.t_data : 2'd0;
      pe_newline = tBeat & firstBeat;
   end

   assign pe_active       = qLen;
   assign host.q_ready    = qReadyR;
   assign host.t_ready    = tReadyR;
   assign host.busy       = busyR;
   assign host.done       = doneR;
   assign host.error      = errorR;
   assign host.best_score = bestR;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl. The PE chain is replaced by a stand-in
// that presents the next value of a score table on every enabled cycle and
// otherwise holds its registered output, like a frozen chain.
module tb_sw_array_ctrl;
   localparam int NPE  = 4;
   localparam int VW   = 16;
   localparam int LENW = 16;

   localparam logic [15:0] CFG_MATCH = 16'h0002;
   localparam logic [15:0] CFG_MIS   = 16'hFFFF;
   localparam logic [15:0] CFG_ALPHA = 16'hFFFE;
   localparam logic [15:0] CFG_BETA  = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        peShift;
   logic [1:0]  peSData;
   logic        peEn;
   logic [1:0]  peT;
   logic        peNewline;
   logic [15:0] peActive;
   logic [15:0] match;
   logic [15:0] mismatch;
   logic [15:0] minusAlpha;
   logic [15:0] minusBeta;
   logic [15:0] chainScore;

   int          total = 0;
   int          bad   = 0;
   logic [1:0]  qSym [0:3];
   logic [1:0]  tSym [0:3];
   logic [15:0] scoreTab [0:15];
   int          enCount;
   bit          clearChain;

   always #5 clk = ~clk;

   sw_array_ctrl_if #(.VW(VW), .LENW(LENW)) bus ();

   sw_array_ctrl #(.NUM_PE(NPE), .VW(VW), .LENW(LENW)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (bus),
      .pe_s_shift  (peShift),
      .pe_s_data   (peSData),
      .pe_en       (peEn),
      .pe_t        (peT),
      .pe_newline  (peNewline),
      .pe_active   (peActive),
      .match       (match),
      .mismatch    (mismatch),
      .minus_alpha (minusAlpha),
      .minus_beta  (minusBeta),
      .score_in    (chainScore)
   );

   // Chain stand-in: registered score advances only when pe_en is high
   always @(posedge clk) begin
      if (clearChain) begin
         enCount <= 0;
      end else if (peEn) begin
         chainScore <= scoreTab[enCount[3:0]];
         enCount    <= enCount + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic loadTab(input logic [127:0] v);
      for (int i = 0; i < 16; i++)
         scoreTab[i] = (i < 8) ? v[(7-i)*16 +: 16] : 16'd0;
   endtask

   // One complete job; returns in the done cycle (or after an abort).
   task automatic runJob(input int ql, input int tl, input bit bubbles,
                         input bit pokeStart, input bit abortDrain,
                         input logic [15:0] expBest);
      int beat;
      bit gap;
      bus.start           = 1'b1;
      bus.q_len           = ql[15:0];
      bus.t_len           = tl[15:0];
      bus.cfg_match       = CFG_MATCH;
      bus.cfg_mismatch    = CFG_MIS;
      bus.cfg_minus_alpha = CFG_ALPHA;
      bus.cfg_minus_beta  = CFG_BETA;
      clearChain          = 1'b1;
      tick();
      bus.start  = 1'b0;
      clearChain = 1'b0;
      #1;
      check("busy_after_start", bus.busy, 1);
      check("q_ready_after_start", bus.q_ready, 1);
      check("t_ready_in_load", bus.t_ready, 0);
      check("best_cleared", bus.best_score, 0);
      check("pe_active", peActive, ql);
      check("match_latched", match, CFG_MATCH);
      check("alpha_latched", minusAlpha, CFG_ALPHA);
      for (int i = 0; i < ql; i++) begin
         bus.q_valid = 1'b1;
         bus.q_data  = qSym[i];
         #1;
         check("load_shift", peShift, 1);
         check("load_sdata", peSData, qSym[i]);
         check("load_pe_en", peEn, 0);
         tick();
      end
      bus.q_valid = 1'b0;
      #1;
      check("q_ready_after_load", bus.q_ready, 0);
      check("t_ready_after_load", bus.t_ready, 1);
      beat = 0;
      gap  = 1'b0;
      while (beat < tl) begin
         if (bubbles && gap) begin
            bus.t_valid = 1'b0;
            #1;
            check("bubble_pe_en", peEn, 0);
            check("bubble_newline", peNewline, 0);
            check("bubble_pe_t", peT, 0);
            tick();
            gap = 1'b0;
         end else begin
            bus.t_valid = 1'b1;
            bus.t_data  = tSym[beat];
            if (pokeStart && beat == 1) begin
               bus.start     = 1'b1;
               bus.q_len     = 16'd1;
               bus.cfg_match = 16'h0007;
            end
            #1;
            check("run_pe_en", peEn, 1);
            check("run_pe_t", peT, tSym[beat]);
            check("run_newline", peNewline, (beat == 0));
            tick();
            bus.start     = 1'b0;
            bus.q_len     = ql[15:0];
            bus.cfg_match = CFG_MATCH;
            beat++;
            gap = 1'b1;
         end
      end
      bus.t_valid = 1'b0;
      for (int d = 1; d <= ql; d++) begin
         if (abortDrain && d == 2) begin
            rst = 1'b1;
            tick();
            check("abort_busy", bus.busy, 0);
            check("abort_done", bus.done, 0);
            check("abort_pe_en", peEn, 0);
            check("abort_q_ready", bus.q_ready, 0);
            check("abort_t_ready", bus.t_ready, 0);
            check("abort_best", bus.best_score, 0);
            check("abort_match", match, 0);
            check("abort_pe_active", peActive, 0);
            rst = 1'b0;
            for (int k = 0; k < 4; k++) begin
               tick();
               check("abort_no_done", bus.done, 0);
            end
            return;
         end
         #1;
         check("drain_pe_en", peEn, 1);
         check("drain_pe_t", peT, 0);
         check("drain_newline", peNewline, 0);
         check("drain_busy", bus.busy, 1);
         tick();
      end
      check("finish_pe_en", peEn, 0);
      check("finish_busy", bus.busy, 1);
      check("finish_done", bus.done, 0);
      tick();
      check("done_pulse", bus.done, 1);
      check("done_busy", bus.busy, 0);
      check("done_error", bus.error, 0);
      check("done_best", bus.best_score, expBest);
      check("done_match", match, CFG_MATCH);
      check("done_pe_active", peActive, ql);
   endtask

   initial begin
      int eq [3];
      int et [3];
      eq = '{0, 5, 2};
      et = '{4, 4, 0};
      rst                 = 1'b1;
      clearChain          = 1'b0;
      bus.start           = 1'b0;
      bus.q_len           = '0;
      bus.t_len           = '0;
      bus.cfg_match       = '0;
      bus.cfg_mismatch    = '0;
      bus.cfg_minus_alpha = '0;
      bus.cfg_minus_beta  = '0;
      bus.q_valid         = 1'b0;
      bus.q_data          = '0;
      bus.t_valid         = 1'b0;
      bus.t_data          = '0;
      loadTab('0);
      tick();
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_error", bus.error, 0);
      check("rst_best", bus.best_score, 0);
      check("rst_q_ready", bus.q_ready, 0);
      check("rst_t_ready", bus.t_ready, 0);
      check("rst_pe_en", peEn, 0);
      check("rst_pe_active", peActive, 0);
      check("rst_match", match, 0);
      rst = 1'b0;
      tick();

      // Streams offered while idle must not reach the chain
      bus.q_valid = 1'b1;
      bus.t_valid = 1'b1;
      #1;
      check("idle_shift", peShift, 0);
      check("idle_pe_en", peEn, 0);
      bus.q_valid = 1'b0;
      bus.t_valid = 1'b0;
      tick();

      // Job 1: q=ACGT, t=ACGT; peak score arrives on the last drain sample
      qSym = '{2'd0, 2'd1, 2'd2, 2'd3};
      tSym = '{2'd0, 2'd1, 2'd2, 2'd3};
      loadTab({16'd2, 16'd2, 16'd4, 16'd2, 16'd4, 16'd6, 16'd6, 16'd8});
      runJob(4, 4, 1'b0, 1'b0, 1'b0, 16'd8);
      tick();
      check("j1_done_low", bus.done, 0);
      check("j1_best_held", bus.best_score, 8);

      // Job 2: same job with target bubbles every other cycle
      runJob(4, 4, 1'b1, 1'b0, 1'b0, 16'd8);
      tick();

      // Illegal lengths: q_len=0, q_len>NUM_PE, t_len=0
      for (int i = 0; i < 3; i++) begin
         bus.start = 1'b1;
         bus.q_len = eq[i][15:0];
         bus.t_len = et[i][15:0];
         tick();
         bus.start = 1'b0;
         #1;
         check("err_done", bus.done, 1);
         check("err_error", bus.error, 1);
         check("err_busy", bus.busy, 0);
         check("err_q_ready", bus.q_ready, 0);
         tick();
         check("err_done_low", bus.done, 0);
         check("err_busy_low", bus.busy, 0);
         check("err_q_ready_low", bus.q_ready, 0);
         check("err_t_ready_low", bus.t_ready, 0);
      end

      // Job 4: q=AAAA, t=CCCC; stale chain output must not leak in
      qSym = '{2'd0, 2'd0, 2'd0, 2'd0};
      tSym = '{2'd1, 2'd1, 2'd1, 2'd1};
      loadTab('0);
      runJob(4, 4, 1'b0, 1'b1, 1'b0, 16'd0);
      tick();

      // Job 5: reset during drain, then a full job with an MSB-set score
      qSym = '{2'd0, 2'd1, 2'd2, 2'd3};
      tSym = '{2'd0, 2'd1, 2'd2, 2'd3};
      loadTab({16'd2, 16'd2, 16'd4, 16'd2, 16'd4, 16'd6, 16'd6, 16'd8});
      runJob(4, 4, 1'b0, 1'b0, 1'b1, 16'd0);
      loadTab({16'd1, 16'hFFF0, 16'd3, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0});
      runJob(4, 4, 1'b0, 1'b0, 1'b0, 16'hFFF0);

      // Start in the done cycle is ignored; the next cycle starts job 6
      bus.start = 1'b1;
      bus.q_len = 16'd2;
      bus.t_len = 16'd3;
      tick();
      check("start_on_done_ignored", bus.busy, 0);
      qSym = '{2'd2, 2'd0, 2'd0, 2'd0};
      tSym = '{2'd2, 2'd0, 2'd3, 2'd0};
      loadTab({16'd3, 16'd1, 16'd5, 16'd2, 16'd4, 16'd0, 16'd0, 16'd0});
      runJob(2, 3, 1'b0, 1'b0, 1'b0, 16'd5);
      tick();
      check("j6_done_low", bus.done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
